// File: rtl/lsu_pkg.sv
// ============================================================================
// lsu_pkg : shared funct3 encodings and FSM state type for the dmem LSU
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        WR_MERGE = 2'd2,
        RESP     = 2'd3
    } lsu_state_e;

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// lsu_align : byte-lane extract/extend, store lane merge and legality checks
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_i,
    input  logic        is_store_i,
    input  logic [31:0] word_i,
    input  logic [15:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_word_o,
    output logic        misaligned_o,
    output logic        illegal_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{addr_i, 3'b000} +: 8];
        half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];

        load_data_o = '0;
        case (funct3_i)
            F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data_o = {24'd0, byte_sel};
            F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data_o = {16'd0, half_sel};
            F3_W:    load_data_o = word_i;
            default: load_data_o = '0;
        endcase

        // Untouched lanes keep the word just read back from memory
        merged_word_o = word_i;
        if (funct3_i == F3_B) begin
            merged_word_o[{addr_i, 3'b000} +: 8] = wdata_i[7:0];
        end else if (funct3_i == F3_H) begin
            if (addr_i[1]) merged_word_o[31:16] = wdata_i;
            else           merged_word_o[15:0]  = wdata_i;
        end

        if (is_store_i)
            illegal_o = !(funct3_i == F3_B || funct3_i == F3_H || funct3_i == F3_W);
        else
            illegal_o = !(funct3_i == F3_B || funct3_i == F3_H || funct3_i == F3_W ||
                          funct3_i == F3_BU || funct3_i == F3_HU);

        misaligned_o = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                       ((funct3_i[1:0] == 2'b10) && (addr_i != 2'b00));
    end

endmodule

`default_nettype wire

// File: rtl/dmem_lsu.sv
// ============================================================================
// dmem_lsu : RV32 load/store unit in front of a word-wide BRAM port A
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2   // 1 or 2 only
) (
    input  logic              clka,
    input  logic              rstb,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              bram_en,
    output logic              bram_we,
    output logic              bram_regce,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout
);

    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

    lsu_state_e        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              ready_c, en_c, we_c;
    logic [2:0]        al_f3;
    logic [1:0]        al_addr;
    logic              al_store;
    logic [31:0]       al_load, al_merged;
    logic              al_misaligned, al_illegal;

    logic              unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    // Legality is judged on the live request in IDLE, lane work on captured fields later
    assign al_f3    = (state_q == IDLE) ? req_funct3   : f3_q;
    assign al_addr  = (state_q == IDLE) ? req_addr[1:0] : addr_q[1:0];
    assign al_store = (state_q == IDLE) ? req_we       : we_q;

    lsu_align u_align (
        .funct3_i      (al_f3),
        .addr_i        (al_addr),
        .is_store_i    (al_store),
        .word_i        (bram_dout),
        .wdata_i       (wdata_q),
        .load_data_o   (al_load),
        .merged_word_o (al_merged),
        .misaligned_o  (al_misaligned),
        .illegal_o     (al_illegal)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        f3_d      = f3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        ready_c   = 1'b0;
        en_c      = 1'b0;
        we_c      = 1'b0;
        bram_addr = addr_q[ADDR_W+1:2];
        bram_din  = '0;

        case (state_q)
            IDLE: begin
                ready_c   = 1'b1;
                bram_addr = req_addr[ADDR_W+1:2];
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr[ADDR_W+1:0];
                    wdata_d = req_wdata[15:0];
                    rdata_d = '0;
                    err_d   = al_misaligned | al_illegal;
                    if (al_misaligned | al_illegal) begin
                        state_d = RESP;
                    end else if (req_we && req_funct3 == F3_W) begin
                        en_c     = 1'b1;
                        we_c     = 1'b1;
                        bram_din = req_wdata;
                        state_d  = RESP;
                    end else begin
                        en_c    = 1'b1;
                        cnt_d   = CNT_INIT;
                        state_d = (req_we && RD_LAT == 1) ? WR_MERGE : RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
                // Sub-word stores hop to WR_MERGE so the write lands on the data-valid cycle
                if (we_q) begin
                    if (cnt_q == 2'd1) state_d = WR_MERGE;
                end else if (cnt_q == 2'd0) begin
                    rdata_d = al_load;
                    state_d = RESP;
                end
            end
            WR_MERGE: begin
                en_c     = 1'b1;
                we_c     = 1'b1;
                bram_din = al_merged;
                state_d  = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (rstb) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = ready_c & ~rstb;
    assign bram_en    = en_c & ~rstb;
    assign bram_we    = we_c & ~rstb;
    assign bram_regce = 1'b1;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

`default_nettype wire

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit sitting directly upstream of the data-memory bram_module (port A). It turns RV32IM core memory requests (byte address, funct3, store data) into word-wide BRAM accesses.
- Byte/halfword loads: lane extraction plus sign/zero extension.
- Byte/halfword stores: read-modify-write, because BRAM write enable is whole-word.
- Misaligned and illegal accesses are flagged instead of issued. One request outstanding at a time.

Parameters:
- ADDR_W, 15, BRAM word-address width (32768 words).
- DATA_W, 32, data width; fixed at 32, other values unsupported.
- RD_LAT, 2, BRAM read latency in cycles; 2 = HIGH_PERFORMANCE, 1 = LOW_LATENCY; only 1 or 2 legal.

Ports:
- clka  in  1  clock
- rstb  in  1  reset, synchronous, active-high
- req_valid  in  1  core request valid
- req_ready  out  1  LSU can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 load/store funct3
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low bytes used for SB/SH)
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  misaligned or illegal funct3
- bram_en  out  1  to bram ena
- bram_we  out  1  to bram wea
- bram_regce  out  1  to bram regcea; tied 1
- bram_addr  out  ADDR_W  word address, req_addr[ADDR_W+1:2]
- bram_din  out  32  to bram dina
- bram_dout  in  32  from bram douta

Behaviour:
- Clock and reset: clka clocks everything. rstb is synchronous, active-high.
- Reset values: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, counter=0. While rstb=1: req_ready=0, bram_en=0, bram_we=0.
- Acceptance:
  - Handshake at req_valid&req_ready, cycle T. req_ready=1 only in IDLE.
  - Request fields are captured into registers at T. Address bits above ADDR_W+1 are ignored (aliasing).
  - The core must hold fields stable only during T.
- Legality:
  - Loads: funct3 000/001/010/100/101. Stores: 000/001/010. Anything else is illegal.
  - Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
  - Error path: no BRAM access at all; resp_valid=1, resp_err=1, resp_rdata=0 in cycle T+1.
- FSM states: IDLE, RD_WAIT, WR_MERGE, RESP.
  - IDLE, on accept:
    - SW: bram_en=1, bram_we=1, bram_din=wdata during T (combinational) -> RESP.
    - Load or SB/SH: bram_en=1, bram_we=0 during T -> RD_WAIT, counter=RD_LAT-1.
    - Error -> RESP with err set.
  - RD_WAIT: counter decrements each cycle. In cycle T+RD_LAT, bram_dout holds the addressed word.
    - Load: extract/extend, register into resp_rdata -> RESP.
    - SB/SH -> WR_MERGE.
    - For RD_LAT=1, RD_WAIT lasts one cycle.
  - WR_MERGE: same cycle T+RD_LAT (no extra cycle). bram_en=1, bram_we=1, bram_din = bram_dout with lane replaced -> RESP.
  - RESP: resp_valid=1 for exactly one cycle -> IDLE.
- Latency, accept to resp_valid: SW 1; error 1; loads and SB/SH RD_LAT+1. Next accept is possible the cycle after resp_valid.
- Load extract:
  - LB/LBU: byte lane addr[1:0]; bit 7 sign-extended / zero-extended.
  - LH/LHU: lane addr[1]; bit 15 sign-extended / zero-extended.
  - LW: whole word.
- Store merge:
  - SB: lane addr[1:0] <= wdata[7:0].
  - SH: lane addr[1] <= wdata[15:0].
  - Other lanes come from the read word.
- Reset mid-operation:
  - Return to IDLE; no resp_valid for the aborted request.
  - An RMW whose write has not yet issued is dropped, so memory is unchanged.
  - A BRAM write already issued stands.
- bram_regce is constant 1. bram_en=0 whenever no access is issued.

Decomposition:
- lsu_pkg holds:
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - state enum: IDLE, RD_WAIT, WR_MERGE, RESP.
- Sub-module lsu_align: combinational.
  - Inputs: funct3, addr[1:0], word, wdata.
  - Outputs: load_data, merged_word, misaligned, illegal.
  - Shared by the load and RMW paths.

Test Plan:
Preload word 0x40 (byte 0x100) = 0x88776655. RD_LAT=2.
1. LW 0x100 -> bram_en at T with addr 0x040; resp_valid at T+3; rdata 0x88776655; err 0.
2. LB 0x103 -> 0xFFFFFF88. LBU 0x103 -> 0x00000088. LH 0x102 -> 0xFFFF8877. LHU 0x100 -> 0x00006655.
3. SB 0x101, wdata 0x123456AA -> read at T; bram_we at T+2 with din 0x8877AA55; resp at T+3. A following LW 0x100 -> 0x8877AA55.
4. SH 0x101 and LW 0x102 -> bram_en never asserted; resp_valid at T+1, err=1, rdata 0. Load funct3=011 -> same error response.
5. SW 0x200, wdata 0xDEADBEEF -> bram_en=bram_we=1 at T with addr 0x080; resp at T+1. A following LW 0x200 -> 0xDEADBEEF.
6. SB 0x101 with rstb=1 at T+1 -> no bram_we, no resp_valid, req_ready=0 during reset. Afterwards LW 0x100 -> 0x88776655 unchanged.
